t3_2_stage: RTL and testbench

//  Second half of MAF pipeline stage 3; sits directly after the stage-3 first half (Wallace L3 + shifter/reverse).

---
 rtl/t3_2_if.sv | 52 +++++
 rtl/t3_2_stage.sv | 153 +++++++++++++++
 tb/tb_t3_2_stage.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t3_2_if.sv
// Stage-3 second-half bundle: upstream partial-product beat in,
// carry-save beat with sideband out, each with a valid/ready handshake.
interface t3_2_if #(
    parameter int ROW_W = 48,
    parameter int ADD_W = 74
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           cont;
    logic [6*ROW_W-1:0]   level3_in;
    logic [ADD_W-1:0]     sh_rev_in;
    logic [3:0]           sti_in;
    logic [5:0]           signs_in;
    logic [3:0]           trap_in_0;
    logic [3:0]           trap_in_1;
    logic [2:0]           trap_ans_in_0;
    logic [2:0]           trap_ans_in_1;
    logic [11:0]          d_in;
    logic [11:0]          e_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [ADD_W-1:0]     sum_out;
    logic [ADD_W-1:0]     carry_out;
    logic [3:0]           sti_out;
    logic [5:0]           signs_out;
    logic [3:0]           trap_out_0;
    logic [3:0]           trap_out_1;
    logic [2:0]           trap_ans_out_0;
    logic [2:0]           trap_ans_out_1;
    logic [2:0]           cont_out;
    logic [11:0]          d_out;
    logic [11:0]          e_out;

    modport master (
        output in_valid, cont, level3_in, sh_rev_in, sti_in, signs_in,
               trap_in_0, trap_in_1, trap_ans_in_0, trap_ans_in_1,
               d_in, e_in, out_ready,
        input  in_ready, out_valid, sum_out, carry_out, sti_out,
               signs_out, trap_out_0, trap_out_1, trap_ans_out_0,
               trap_ans_out_1, cont_out, d_out, e_out
    );

    modport slave (
        input  in_valid, cont, level3_in, sh_rev_in, sti_in, signs_in,
               trap_in_0, trap_in_1, trap_ans_in_0, trap_ans_in_1,
               d_in, e_in, out_ready,
        output in_ready, out_valid, sum_out, carry_out, sti_out,
               signs_out, trap_out_0, trap_out_1, trap_ans_out_0,
               trap_ans_out_1, cont_out, d_out, e_out
    );
endinterface

// File: rtl/t3_2_stage.sv
// MAF stage 3, second half: 7:2 CSA reduction into a 2-entry skid buffer.
// Optional T3_2_TRAP_BYPASS_EN zeroes sum/carry of trapping lanes.
module t3_2_stage #(
    parameter int ROW_W    = 48,
    parameter int ADD_W    = 74,
    parameter int LANE_CUT = 24
) (
    input  logic   clk,
    input  logic   rst,
    t3_2_if.slave  bus
);

    typedef struct packed {
        logic [ADD_W-1:0] sum;
        logic [ADD_W-1:0] carry;
        logic [3:0]       sti;
        logic [5:0]       signs;
        logic [3:0]       trap0;
        logic [3:0]       trap1;
        logic [2:0]       ans0;
        logic [2:0]       ans1;
        logic [2:0]       cont;
        logic [11:0]      d;
        logic [11:0]      e;
    } beat_t;

    // cmask clears the carry landing on LANE_CUT in dual-lane mode
    function automatic logic [2*ROW_W-1:0] csa(
        input logic [ROW_W-1:0] a,
        input logic [ROW_W-1:0] b,
        input logic [ROW_W-1:0] c,
        input logic [ROW_W-1:0] cmask
    );
        logic [ROW_W-1:0] s;
        logic [ROW_W-1:0] cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy & cmask, s};
    endfunction

    logic             dual;
    logic [ROW_W-1:0] cmask;
    logic [ROW_W-1:0] row [6];
    logic [ROW_W-1:0] s1, c1, s2, c2, s3, c3, s4, c4, sf, cf;
    logic [ROW_W-1:0] kill;
    beat_t            nb;

    always_comb begin
        dual = (bus.cont == 3'b001);
        cmask = '1;
        if (dual) cmask[LANE_CUT] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            row[i] = bus.level3_in[i*ROW_W +: ROW_W];
        end
        {c1, s1} = csa(row[0], row[1], row[2], cmask);
        {c2, s2} = csa(row[3], row[4], row[5], cmask);
        {c3, s3} = csa(s1, c1, s2, cmask);
        {c4, s4} = csa(s3, c3, c2, cmask);
        {cf, sf} = csa(s4, c4, bus.sh_rev_in[ROW_W-1:0], cmask);
        kill = '0;
`ifdef T3_2_TRAP_BYPASS_EN
        if (dual) begin
            if (bus.trap_in_0 != 4'h0) kill[LANE_CUT-1:0] = '1;
            if (bus.trap_in_1 != 4'h0) kill[ROW_W-1:LANE_CUT] = '1;
        end else if (bus.trap_in_0 != 4'h0) begin
            kill = '1;
        end
`endif
        nb       = '0;
        nb.sum   = {bus.sh_rev_in[ADD_W-1:ROW_W], sf & ~kill};
        nb.carry = {{(ADD_W-ROW_W){1'b0}}, cf & ~kill};
        nb.sti   = bus.sti_in;
        nb.signs = bus.signs_in;
        nb.trap0 = bus.trap_in_0;
        nb.trap1 = bus.trap_in_1;
        nb.ans0  = bus.trap_ans_in_0;
        nb.ans1  = bus.trap_ans_in_1;
        nb.cont  = bus.cont;
        nb.d     = bus.d_in;
        nb.e     = bus.e_in;
    end

    logic [1:0] cnt_q, cnt_d;
    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       push, pop;

    always_comb begin
        push   = bus.in_valid && in_ready_q;
        pop    = out_valid_q && bus.out_ready;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = nb;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = nb;
                end else if (push) begin
                    tail_d = nb;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (cnt_d < 2'd2);
            out_valid_q <= (cnt_d != 2'd0);
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.sum_out        = head_q.sum;
    assign bus.carry_out      = head_q.carry;
    assign bus.sti_out        = head_q.sti;
    assign bus.signs_out      = head_q.signs;
    assign bus.trap_out_0     = head_q.trap0;
    assign bus.trap_out_1     = head_q.trap1;
    assign bus.trap_ans_out_0 = head_q.ans0;
    assign bus.trap_ans_out_1 = head_q.ans1;
    assign bus.cont_out       = head_q.cont;
    assign bus.d_out          = head_q.d;
    assign bus.e_out          = head_q.e;

endmodule

// File: tb/tb_t3_2_stage.sv
// Bench for t3_2_stage: directed scenarios plus a randomized
// scoreboard against a lane-sum reference model.
module tb_t3_2_stage;

    typedef struct packed {
        logic [2:0]   cont;
        logic [287:0] lv;
        logic [73:0]  sh;
        logic [3:0]   sti;
        logic [5:0]   sg;
        logic [3:0]   t0;
        logic [3:0]   t1;
        logic [2:0]   a0;
        logic [2:0]   a1;
        logic [11:0]  d;
        logic [11:0]  e;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    t3_2_if bus ();

    t3_2_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t q[$];
    beat_t last_b;
    beat_t cur;

    // Expected S+C: whole 48b sum, or two independent 24b lane sums.
    function automatic logic [47:0] exp_low(beat_t b);
        logic [47:0] tot;
        logic [23:0] l0;
        logic [23:0] l1;
        logic [47:0] op;
        tot = '0;
        l0  = '0;
        l1  = '0;
        for (int i = 0; i < 7; i++) begin
            op  = (i < 6) ? b.lv[48*i +: 48] : b.sh[47:0];
            tot = tot + op;
            l0  = l0 + op[23:0];
            l1  = l1 + op[47:24];
        end
`ifdef T3_2_TRAP_BYPASS_EN
        if (b.cont == 3'b001) begin
            if (b.t0 != 4'h0) l0 = '0;
            if (b.t1 != 4'h0) l1 = '0;
        end else if (b.t0 != 4'h0) begin
            tot = '0;
        end
`endif
        return (b.cont == 3'b001) ? {l1, l0} : tot;
    endfunction

    function automatic logic [47:0] obs_low(logic [2:0] cont,
                                            logic [73:0] s,
                                            logic [73:0] c);
        logic [23:0] l0;
        logic [23:0] l1;
        logic [47:0] t;
        l0 = s[23:0] + c[23:0];
        l1 = s[47:24] + c[47:24];
        t  = s[47:0] + c[47:0];
        return (cont == 3'b001) ? {l1, l0} : t;
    endfunction

    function automatic logic [50:0] side_of(beat_t b);
        return {b.cont, b.sti, b.sg, b.t0, b.t1, b.a0, b.a1, b.d, b.e};
    endfunction

    function automatic logic [50:0] side_out();
        return {bus.cont_out, bus.sti_out, bus.signs_out,
                bus.trap_out_0, bus.trap_out_1, bus.trap_ans_out_0,
                bus.trap_ans_out_1, bus.d_out, bus.e_out};
    endfunction

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [95:0] w;
        for (int i = 0; i < 9; i++) b.lv[32*i +: 32] = $urandom;
        w      = {$urandom, $urandom, $urandom};
        b.sh   = w[73:0];
        b.cont = 3'($urandom_range(0, 7));
        b.sti  = 4'($urandom);
        b.sg   = 6'($urandom);
        b.t0   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        b.t1   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        b.a0   = 3'($urandom);
        b.a1   = 3'($urandom);
        b.d    = 12'($urandom);
        b.e    = 12'($urandom);
        return b;
    endfunction

    task automatic drive(beat_t b, logic v);
        cur               = b;
        bus.in_valid      = v;
        bus.cont          = b.cont;
        bus.level3_in     = b.lv;
        bus.sh_rev_in     = b.sh;
        bus.sti_in        = b.sti;
        bus.signs_in      = b.sg;
        bus.trap_in_0     = b.t0;
        bus.trap_in_1     = b.t1;
        bus.trap_ans_in_0 = b.a0;
        bus.trap_ans_in_1 = b.a1;
        bus.d_in          = b.d;
        bus.e_in          = b.e;
    endtask

    // Advance one clock and update the reference FIFO from the handshake.
    task automatic tick();
        bit in_f;
        bit out_f;
        in_f  = bus.in_valid && (q.size() < 2);
        out_f = bus.out_ready && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_b = '0;
        end else begin
            if (out_f) begin
                last_b = q[0];
                void'(q.pop_front());
            end
            if (in_f) q.push_back(cur);
        end
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive('0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_tests++;
        if (bus.sum_out !== '0 || bus.carry_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data: sum %h carry %h want 0",
                     bus.sum_out, bus.carry_out);
        end
        n_tests++;
        if (side_out() !== '0) begin
            n_fail++;
            $display("FAIL reset_side: got %h want 0", side_out());
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        beat_t b;
        logic [73:0] tot;
        b = '0;
        for (int i = 0; i < 6; i++) b.lv[48*i +: 48] = 48'(i + 1);
        b.sh = 74'h10;
        drive(b, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        drive('0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: got %b want 1", bus.out_valid);
        end
        tot = bus.sum_out + bus.carry_out;
        n_tests++;
        if (tot !== 74'h25) begin
            n_fail++;
            $display("FAIL basic_sum: got %h want 25", tot);
        end
        n_tests++;
        if (bus.carry_out[73:48] !== '0) begin
            n_fail++;
            $display("FAIL basic_carry_hi: got %h want 0", bus.carry_out[73:48]);
        end
        tick();
    endtask

    task automatic test_dual();
        beat_t b;
        logic [47:0] l;
        b = '0;
        b.cont = 3'b001;
        b.lv[47:0]  = 48'h000000_FFFFFF;
        b.lv[95:48] = 48'h000000_FFFFFF;
        drive(b, 1'b1);
        tick();
        drive('0, 1'b0);
        @(negedge clk);
        l = obs_low(3'b001, bus.sum_out, bus.carry_out);
        n_tests++;
        if (l[23:0] !== 24'hFFFFFE) begin
            n_fail++;
            $display("FAIL dual_lane0: got %h want fffffe", l[23:0]);
        end
        n_tests++;
        if (l[47:24] !== 24'h0) begin
            n_fail++;
            $display("FAIL dual_lane1: got %h want 0", l[47:24]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        beat_t a;
        beat_t b;
        beat_t c;
        a = rand_beat(); a.d = 12'd1;
        b = rand_beat(); b.d = 12'd2;
        c = rand_beat(); c.d = 12'd3;
        bus.out_ready = 1'b0;
        drive(a, 1'b1);
        tick();
        drive(b, 1'b1);
        tick();
        drive(c, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.d_out !== 12'd1) begin
            n_fail++;
            $display("FAIL bp_full: rdy %b vld %b d %0d want 0 1 1",
                     bus.in_ready, bus.out_valid, bus.d_out);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.d_out !== 12'd1) begin
            n_fail++;
            $display("FAIL bp_hold: rdy %b d %0d want 0 1",
                     bus.in_ready, bus.d_out);
        end
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.d_out !== 12'd2) begin
            n_fail++;
            $display("FAIL bp_second: rdy %b d %0d want 1 2",
                     bus.in_ready, bus.d_out);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.d_out !== 12'd3 ||
            obs_low(c.cont, bus.sum_out, bus.carry_out) !== exp_low(c)) begin
            n_fail++;
            $display("FAIL bp_third: vld %b d %0d low %h want 1 3 %h",
                     bus.out_valid, bus.d_out,
                     obs_low(c.cont, bus.sum_out, bus.carry_out), exp_low(c));
        end
        drive(c, 1'b0);
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.d_out !== 12'd3) begin
            n_fail++;
            $display("FAIL bp_empty: vld %b d %0d want 0 3",
                     bus.out_valid, bus.d_out);
        end
    endtask

    task automatic test_back_to_back();
        beat_t prev;
        beat_t nb;
        prev = rand_beat();
        prev.d = 12'd100;
        bus.out_ready = 1'b0;
        drive(prev, 1'b1);
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nb = rand_beat();
            nb.d = 12'(200 + i);
            drive(nb, 1'b1);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
                bus.d_out !== prev.d ||
                obs_low(prev.cont, bus.sum_out, bus.carry_out) !== exp_low(prev)) begin
                n_fail++;
                $display("FAIL b2b_%0d: vld %b rdy %b d %0d want 1 1 %0d",
                         i, bus.out_valid, bus.in_ready, bus.d_out, prev.d);
            end
            prev = nb;
            tick();
        end
        drive(prev, 1'b0);
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.d_out !== prev.d) begin
            n_fail++;
            $display("FAIL b2b_last: vld %b d %0d want 1 %0d",
                     bus.out_valid, bus.d_out, prev.d);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: vld %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_trap();
        beat_t b;
        logic [47:0] tot;
        b = rand_beat();
        b.cont = 3'b000;
        b.t0 = 4'h2;
        b.t1 = 4'h0;
        b.lv[47:0] = 48'h1234_5678_9ABC;
        tot = '0;
        for (int i = 0; i < 6; i++) tot = tot + b.lv[48*i +: 48];
        tot = tot + b.sh[47:0];
        drive(b, 1'b1);
        tick();
        drive(b, 1'b0);
        @(negedge clk);
`ifdef T3_2_TRAP_BYPASS_EN
        n_tests++;
        if (bus.sum_out[47:0] !== '0 || bus.carry_out[47:0] !== '0) begin
            n_fail++;
            $display("FAIL trap_zero: sum %h carry %h want 0",
                     bus.sum_out[47:0], bus.carry_out[47:0]);
        end
`else
        n_tests++;
        if (obs_low(3'b000, bus.sum_out, bus.carry_out) !== tot) begin
            n_fail++;
            $display("FAIL trap_sum: got %h want %h",
                     obs_low(3'b000, bus.sum_out, bus.carry_out), tot);
        end
`endif
        n_tests++;
        if (bus.trap_out_0 !== 4'h2 || bus.sum_out[73:48] !== b.sh[73:48]) begin
            n_fail++;
            $display("FAIL trap_fwd: trap %h hi %h want 2 %h",
                     bus.trap_out_0, bus.sum_out[73:48], b.sh[73:48]);
        end
        tick();
    endtask

    task automatic test_random();
        beat_t hd;
        for (int i = 0; i < 400; i++) begin
            drive(rand_beat(), 1'($urandom_range(0, 1)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== (q.size() != 0) ||
                bus.in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags_%0d: vld %b rdy %b count %0d",
                         i, bus.out_valid, bus.in_ready, q.size());
            end
            hd = (q.size() != 0) ? q[0] : last_b;
            n_tests++;
            if (obs_low(hd.cont, bus.sum_out, bus.carry_out) !== exp_low(hd) ||
                bus.sum_out[73:48] !== hd.sh[73:48] ||
                bus.carry_out[73:48] !== '0 ||
                side_out() !== side_of(hd)) begin
                n_fail++;
                $display("FAIL rand_data_%0d: low %h side %h want %h %h",
                         i, obs_low(hd.cont, bus.sum_out, bus.carry_out),
                         side_out(), exp_low(hd), side_of(hd));
            end
            tick();
        end
        drive('0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(rand_beat(), 1'b1);
        tick();
        drive(rand_beat(), 1'b1);
        tick();
        drive('0, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.sum_out !== '0 || bus.carry_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: vld %b rdy %b sum %h want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.sum_out);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        last_b = '0;
        test_reset();
        test_basic();
        test_dual();
        test_backpressure();
        test_back_to_back();
        test_trap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
